// File: rtl/mem_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_bus_pkg
// Purpose : Types and constants shared by the SRAM port arbiter, its bus
//           interface and its grant-select sub-module.
// Contents: arb_state_t - arbiter FSM encoding (IDLE / ACCESS / DONE)
//           owner_t     - which requester currently owns the SRAM port
//           BUS_W       - width of the address/data buses
//           CNT_W       - width of the wait-state and streak counters
//           wait_load   - converts a wait-state count to counter width
// ----------------------------------------------------------------------------
package mem_bus_pkg;

    localparam int BUS_W = 16;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_DM   = 2'b10
    } owner_t;

    function automatic logic [CNT_W-1:0] wait_load(input int n);
        return CNT_W'(n);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Purpose : Bundles the two requester handshakes and the external SRAM pins
//           that the arbiter sits between.
// Signals : if_req/if_addr/if_rdata/if_ack                 - fetch requester
//           dm_req/dm_we/dm_addr/dm_wdata/dm_rdata/dm_ack  - data requester
//           sram_addr/sram_dout/sram_doe/sram_din/
//           sram_ce_n/sram_oe_n/sram_we_n                  - SRAM port
// Modports: slave  - the arbiter (serves requests, drives the SRAM)
//           master - the surroundings (requesters and SRAM device)
// ----------------------------------------------------------------------------
interface mem_bus_arbiter_if;
    import mem_bus_pkg::*;

    logic             if_req;
    logic [BUS_W-1:0] if_addr;
    logic [BUS_W-1:0] if_rdata;
    logic             if_ack;

    logic             dm_req;
    logic             dm_we;
    logic [BUS_W-1:0] dm_addr;
    logic [BUS_W-1:0] dm_wdata;
    logic [BUS_W-1:0] dm_rdata;
    logic             dm_ack;

    logic [BUS_W-1:0] sram_addr;
    logic [BUS_W-1:0] sram_dout;
    logic             sram_doe;
    logic [BUS_W-1:0] sram_din;
    logic             sram_ce_n;
    logic             sram_oe_n;
    logic             sram_we_n;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ack,
        output sram_addr, sram_dout, sram_doe, sram_ce_n, sram_oe_n, sram_we_n,
        input  sram_din
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack,
        input  sram_addr, sram_dout, sram_doe, sram_ce_n, sram_oe_n, sram_we_n,
        output sram_din
    );

endinterface

// File: rtl/mem_bus_arbiter_arb_priority_sel.sv
// ----------------------------------------------------------------------------
// arb_priority_sel
// Purpose : Combinational grant choice between the fetch and data requesters.
//           Data normally wins. With ARB_FAIR_EN defined, fetch wins once the
//           data streak has reached its limit while fetch is waiting.
// Macro   : ARB_FAIR_EN - enables the streak-limit override.
// Ports   : i_if_req        in  fetch request pending
//           i_dm_req        in  data request pending
//           i_streak_at_max in  data streak has hit its limit
//           o_grant_if      out grant fetch (at most one grant is high)
//           o_grant_dm      out grant data
// ----------------------------------------------------------------------------
module arb_priority_sel (
    input  logic i_if_req,
    input  logic i_dm_req,
    input  logic i_streak_at_max,
    output logic o_grant_if,
    output logic o_grant_dm
);

    logic w_if_wins;

`ifdef ARB_FAIR_EN
    assign w_if_wins = i_if_req & (~i_dm_req | i_streak_at_max);
`else
    // Strict priority: the streak input is tied low by the parent.
    logic w_streak_unused;
    assign w_streak_unused = i_streak_at_max;
    assign w_if_wins       = i_if_req & ~i_dm_req;
`endif

    assign o_grant_if = w_if_wins;
    assign o_grant_dm = i_dm_req & ~w_if_wins;

endmodule

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
// Purpose : Shares the single 16-bit SRAM port between instruction fetch and
//           the load/store stage. Data has priority; every transfer takes
//           WAIT_CYCLES+1 ACCESS cycles followed by one DONE cycle carrying a
//           single-cycle ack to the owner. All SRAM strobes are registered.
// Macro   : ARB_FAIR_EN - limits consecutive data grants while fetch waits
//           to DM_STREAK_MAX, after which fetch is served once.
// Params  : WAIT_CYCLES   extra SRAM access cycles per transfer (1..7)
//           DM_STREAK_MAX data-grant streak limit (1..7, ARB_FAIR_EN only)
// Ports   : clk  in  system clock, posedge
//           rst  in  asynchronous reset, active low
//           bus  slave modport of mem_bus_arbiter_if (requesters + SRAM)
//
// state  | meaning
// -------+-------------------------------------------------------------------
// IDLE   | port free; sample requests and grant one, latching addr/we/wdata
// ACCESS | strobes active; wait counter runs down, read data taken at 0
// DONE   | strobes released; owner's ack high for this cycle only
// ----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int WAIT_CYCLES   = 1,
    parameter int DM_STREAK_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_bus_arbiter_if.slave         bus
);

    localparam logic [CNT_W-1:0] WAIT_INIT = wait_load(WAIT_CYCLES);

    arb_state_t       r_state;
    owner_t           r_owner;
    logic             r_we;
    logic [CNT_W-1:0] r_cnt;

    logic [BUS_W-1:0] r_sram_addr;
    logic [BUS_W-1:0] r_sram_dout;
    logic             r_sram_doe;
    logic             r_sram_ce_n;
    logic             r_sram_oe_n;
    logic             r_sram_we_n;

    logic             r_if_ack;
    logic             r_dm_ack;
    logic [BUS_W-1:0] r_if_rdata;
    logic [BUS_W-1:0] r_dm_rdata;

    logic             w_grant_if;
    logic             w_grant_dm;
    logic             w_streak_at_max;

    arb_priority_sel u_sel (
        .i_if_req        (bus.if_req),
        .i_dm_req        (bus.dm_req),
        .i_streak_at_max (w_streak_at_max),
        .o_grant_if      (w_grant_if),
        .o_grant_dm      (w_grant_dm)
    );

`ifdef ARB_FAIR_EN
    // Counts data grants taken while fetch was left waiting.
    logic [CNT_W-1:0] r_streak;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak <= '0;
        end else if (r_state == IDLE) begin
            if (w_grant_if) begin
                r_streak <= '0;
            end else if (w_grant_dm) begin
                r_streak <= bus.if_req ? r_streak + 3'd1 : '0;
            end
        end
    end

    assign w_streak_at_max = (r_streak == CNT_W'(DM_STREAK_MAX));
`else
    logic [CNT_W-1:0] w_streak_max_unused;
    assign w_streak_max_unused = CNT_W'(DM_STREAK_MAX);
    assign w_streak_at_max     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_NONE;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_sram_addr <= '0;
            r_sram_dout <= '0;
            r_sram_doe  <= 1'b0;
            r_sram_ce_n <= 1'b1;
            r_sram_oe_n <= 1'b1;
            r_sram_we_n <= 1'b1;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;

            case (r_state)
                IDLE: begin
                    // Strobes for the first ACCESS cycle are set here so they
                    // come straight out of flops.
                    if (w_grant_dm) begin
                        r_state     <= ACCESS;
                        r_owner     <= OWN_DM;
                        r_we        <= bus.dm_we;
                        r_cnt       <= WAIT_INIT;
                        r_sram_addr <= bus.dm_addr;
                        r_sram_dout <= bus.dm_wdata;
                        r_sram_ce_n <= 1'b0;
                        r_sram_oe_n <= bus.dm_we;
                        r_sram_we_n <= ~bus.dm_we;
                        r_sram_doe  <= bus.dm_we;
                    end else if (w_grant_if) begin
                        r_state     <= ACCESS;
                        r_owner     <= OWN_IF;
                        r_we        <= 1'b0;
                        r_cnt       <= WAIT_INIT;
                        r_sram_addr <= bus.if_addr;
                        r_sram_ce_n <= 1'b0;
                        r_sram_oe_n <= 1'b0;
                        r_sram_we_n <= 1'b1;
                        r_sram_doe  <= 1'b0;
                    end
                end

                ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 3'd1;
                        // Release we_n one cycle early so data is held past
                        // the write strobe's rising edge.
                        if (r_cnt == 3'd1) begin
                            r_sram_we_n <= 1'b1;
                        end
                    end else begin
                        r_state     <= DONE;
                        r_sram_ce_n <= 1'b1;
                        r_sram_oe_n <= 1'b1;
                        r_sram_we_n <= 1'b1;
                        r_sram_doe  <= 1'b0;
                        if (r_owner == OWN_DM) begin
                            r_dm_ack <= 1'b1;
                            if (!r_we) begin
                                r_dm_rdata <= bus.sram_din;
                            end
                        end else if (r_owner == OWN_IF) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= bus.sram_din;
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_owner <= OWN_NONE;
                    r_we    <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

    assign bus.sram_addr = r_sram_addr;
    assign bus.sram_dout = r_sram_dout;
    assign bus.sram_doe  = r_sram_doe;
    assign bus.sram_ce_n = r_sram_ce_n;
    assign bus.sram_oe_n = r_sram_oe_n;
    assign bus.sram_we_n = r_sram_we_n;
    assign bus.if_ack    = r_if_ack;
    assign bus.dm_ack    = r_dm_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences the single external 16-bit SRAM port of the naive CPU.
- Shares that port between the instruction-fetch requester (feeds the instruction decoder) and the data-memory requester (load/store stage).
- Fixed priority: data over fetch. Optional fairness limit prevents fetch starvation.
- Generates SRAM strobes with a parameterised wait-state count and a one-cycle ack handshake per requester.

Parameters:
- WAIT_CYCLES, 1, extra SRAM access cycles per transfer; legal range 1..7.
- DM_STREAK_MAX, 4, max consecutive data grants while fetch waits (used only with ARB_FAIR_EN).

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  16  fetch address.
- if_rdata  out  16  fetched instruction; valid in the if_ack cycle and held after.
- if_ack  out  1  one-cycle completion pulse.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  16  data address.
- dm_wdata  in  16  write data.
- dm_rdata  out  16  read data; valid in the dm_ack cycle and held after.
- dm_ack  out  1  one-cycle completion pulse.
- sram_addr  out  16  SRAM address.
- sram_dout  out  16  SRAM write data.
- sram_doe  out  1  drive enable for the bidirectional data pins.
- sram_din  in  16  SRAM read data.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: ce_n=oe_n=we_n=1, doe=0, acks=0, rdata=0, sram_addr=0, sram_dout=0.
  - Internal state: FSM=IDLE, owner=NONE, wait counter=0, streak counter=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Sample requests at posedge.
  - If dm_req=1: grant DM. Otherwise if if_req=1: grant IF. Otherwise stay in IDLE.
  - On grant: latch address, we and wdata into sram_addr/sram_dout; ce_n=0; go to ACCESS; counter=WAIT_CYCLES.
- ACCESS, read grant:
  - oe_n=0, doe=0.
  - Counter decrements each cycle. When counter=0, capture sram_din into the owner's rdata, then go to DONE.
- ACCESS, write grant:
  - doe=1, we_n=0 while counter>0.
  - we_n=1 in the final ACCESS cycle, giving data hold time.
- DONE:
  - Strobes deasserted: ce_n=oe_n=we_n=1, doe=0.
  - Owner's ack=1 for exactly this cycle, then IDLE.
- Latency, request to ack: WAIT_CYCLES+3 cycles (1 IDLE sample + WAIT_CYCLES+1 ACCESS + 1 DONE). WAIT_CYCLES=1 gives 4 cycles.
- Back-to-back transfers: the IDLE cycle after DONE is mandatory. Requesters deassert req in the cycle after ack; a req still high in that IDLE cycle is treated as a new request.
- Simultaneous dm_req and if_req in IDLE: DM wins. IF stays pending; its ack is never produced while it is not granted.
- Request withdrawn mid-transfer: the transfer completes and the ack still pulses. No abort.
- Address and data are latched at grant. Input changes during ACCESS are ignored.
- Reset mid-transfer: strobes deassert immediately (asynchronous) and no ack is issued.
- Only one ack is ever high in any cycle. Strobes are glitch-free (registered outputs).

Optional Feature:
- Macro: ARB_FAIR_EN.
- With it defined:
  - A 3-bit streak counter increments on each DM grant made while if_req=1.
  - It clears on any IF grant, or on a DM grant with if_req=0.
  - When streak=DM_STREAK_MAX and both requests are pending, IF wins.
- Without it: strict DM priority; the streak counter logic is absent.

Decomposition:
- Shared package mem_bus_pkg:
  - FSM state encoding: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10.
  - Owner encoding: NONE, IF, DM.
  - Bus width constant: 16.
- One natural sub-module, arb_priority_sel: combinational grant select from (if_req, dm_req, streak_at_max). It isolates the ARB_FAIR_EN logic.

Test Plan:
- Reset: assert rst=0 mid-ACCESS of a write to 0x0010 -> we_n=1, ce_n=1, doe=0 immediately; no dm_ack; FSM in IDLE after release.
- Single read: if_req with if_addr=0x0004, sram_din=0xA5C3, WAIT_CYCLES=1 -> if_ack pulses exactly 4 cycles after the request edge; if_rdata=0xA5C3; oe_n low for 2 cycles.
- Write: dm_we=1, dm_addr=0x1234, dm_wdata=0xBEEF -> sram_addr=0x1234, sram_dout=0xBEEF; we_n low for WAIT_CYCLES cycles and high in the last ACCESS cycle; dm_ack one cycle; if_ack stays 0.
- Contention: if_req and dm_req rise together -> DM served first; IF granted in the IDLE after dm_ack; if_ack arrives 4 cycles after dm_ack.
- Fairness (ARB_FAIR_EN, DM_STREAK_MAX=4): dm_req held continuously, if_req high -> 4 dm_acks, then if_ack, then DM resumes. Without the macro: if_ack never fires while dm_req stays high.
- Withdrawal: if_req dropped 1 cycle after grant -> if_ack still pulses once, and no second transfer starts.
